// File: rtl/grf_wb_sink.sv
`default_nettype none
// ============================================================================
// Module   : grf_wb_sink
// Purpose  : 32x32 GPR file written from writeback, two bypassed read ports,
//            and a trace FIFO of committed writes with a valid/ready drain.
// Revision : 1.0  initial release
// ============================================================================
module grf_wb_sink #(
    parameter int TRACE_DEPTH = 4,
    parameter int CW          = $clog2(TRACE_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          RFWr_WB,
    input  logic [4:0]    A3_WB,
    input  logic [31:0]   WD_WB,
    input  logic [31:0]   PC_WB,
    input  logic [4:0]    A1,
    input  logic [4:0]    A2,
    output logic [31:0]   RD1,
    output logic [31:0]   RD2,
    output logic          trace_valid,
    input  logic          trace_ready,
    output logic [31:0]   trace_pc,
    output logic [4:0]    trace_addr,
    output logic [31:0]   trace_data,
    output logic [CW-1:0] trace_count,
    output logic          trace_overflow
);

    localparam int PW = $clog2(TRACE_DEPTH);

    logic [31:0]   r_regs [32];
    logic [31:0]   r_tpc  [TRACE_DEPTH];
    logic [4:0]    r_taddr[TRACE_DEPTH];
    logic [31:0]   r_tdata[TRACE_DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic w_we;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_we    = RFWr_WB && (A3_WB != 5'd0);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(TRACE_DEPTH));
    assign w_pop   = !w_empty && trace_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push  = w_we && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[A3_WB] <= WD_WB;
        end
    end

    always_comb begin
        RD1 = r_regs[A1];
        if (A1 == 5'd0) begin
            RD1 = '0;
        end else if (w_we && (A3_WB == A1)) begin
            RD1 = WD_WB;
        end

        RD2 = r_regs[A2];
        if (A2 == 5'd0) begin
            RD2 = '0;
        end else if (w_we && (A3_WB == A2)) begin
            RD2 = WD_WB;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tpc[r_tail]   <= PC_WB;
            r_taddr[r_tail] <= A3_WB;
            r_tdata[r_tail] <= WD_WB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            if (w_we && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign trace_valid    = !w_empty;
    assign trace_pc       = w_empty ? 32'd0 : r_tpc[r_head];
    assign trace_addr     = w_empty ? 5'd0  : r_taddr[r_head];
    assign trace_data     = w_empty ? 32'd0 : r_tdata[r_head];
    assign trace_count    = r_count;
    assign trace_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_grf_wb_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_grf_wb_sink
// Purpose  : Self-checking bench for grf_wb_sink against a queue/array model.
// Revision : 1.0  initial release
// ============================================================================
module tb_grf_wb_sink;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          RFWr_WB;
    logic [4:0]    A3_WB;
    logic [31:0]   WD_WB;
    logic [31:0]   PC_WB;
    logic [4:0]    A1;
    logic [4:0]    A2;
    logic [31:0]   RD1;
    logic [31:0]   RD2;
    logic          trace_valid;
    logic          trace_ready;
    logic [31:0]   trace_pc;
    logic [4:0]    trace_addr;
    logic [31:0]   trace_data;
    logic [CW-1:0] trace_count;
    logic          trace_overflow;

    grf_wb_sink #(.TRACE_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .RFWr_WB(RFWr_WB), .A3_WB(A3_WB),
        .WD_WB(WD_WB), .PC_WB(PC_WB), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
        .trace_count(trace_count), .trace_overflow(trace_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_regs[32];
    bit          m_ovf;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic void model_reset();
        q.delete();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_ovf = 0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (RFWr_WB && A3_WB != 5'd0 && A3_WB == a) return WD_WB;
        return m_regs[a];
    endfunction

    // Architectural effect of one rising edge on the current inputs.
    function automatic void model_edge();
        bit we;
        bit pop;
        ent_t e;
        if (!rst_n) return;
        we  = RFWr_WB && (A3_WB != 5'd0);
        pop = (q.size() > 0) && trace_ready;
        if (pop) void'(q.pop_front());
        if (we) begin
            m_regs[A3_WB] = WD_WB;
            if (q.size() < DEPTH) begin
                e.pc = PC_WB; e.a = A3_WB; e.d = WD_WB;
                q.push_back(e);
            end else begin
                m_ovf = 1;
            end
        end
    endfunction

    task automatic drive(input logic wr, input logic [4:0] a3, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                         input logic rdy);
        RFWr_WB = wr; A3_WB = a3; WD_WB = wd; PC_WB = pc;
        A1 = a1; A2 = a2; trace_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 5'd9, 5'd31, 1);
        rst_n = 1'b0;
        model_reset();
        #7;
        n_checks++;
        if (trace_valid !== 1'b0 || trace_count !== '0 || trace_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: valid=%b count=%0d ovf=%b required 0/0/0",
                     trace_valid, trace_count, trace_overflow);
        end
        n_checks++;
        if (trace_pc !== 32'd0 || trace_addr !== 5'd0 || trace_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_trace_data: pc=%h addr=%0d data=%h required 0", trace_pc, trace_addr, trace_data);
        end
        n_checks++;
        if (RD1 !== 32'd0 || RD2 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_reads: RD1=%h RD2=%h required 0", RD1, RD2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_bypass();
        drive(1, 5'd5, 32'h12345678, 32'h3000, 5'd5, 5'd0, 0);
        #1;
        n_checks++;
        if (RD1 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL bypass_rd1: got %h required %h", RD1, 32'h12345678);
        end
        tick();
        drive(0, 0, 0, 0, 5'd5, 5'd0, 0);
        #1;
        n_checks++;
        if (RD1 !== 32'h12345678) begin
            n_fail++;
            $display("FAIL array_rd1: got %h required %h", RD1, 32'h12345678);
        end
        n_checks++;
        if (trace_valid !== 1'b1 || trace_pc !== 32'h3000 || trace_addr !== 5'd5 ||
            trace_data !== 32'h12345678 || trace_count !== CW'(1)) begin
            n_fail++;
            $display("FAIL first_trace: v=%b pc=%h a=%0d d=%h cnt=%0d required 1/3000/5/12345678/1",
                     trace_valid, trace_pc, trace_addr, trace_data, trace_count);
        end
        trace_ready = 1;
        tick();
        trace_ready = 0;
    endtask

    task automatic test_zero_reg();
        drive(1, 5'd0, 32'hFFFFFFFF, 32'h3004, 5'd0, 5'd0, 0);
        #1;
        n_checks++;
        if (RD1 !== 32'd0 || RD2 !== 32'd0) begin
            n_fail++;
            $display("FAIL zero_reg_reads: RD1=%h RD2=%h required 0", RD1, RD2);
        end
        tick();
        n_checks++;
        if (trace_valid !== 1'b0 || trace_count !== '0) begin
            n_fail++;
            $display("FAIL zero_reg_trace: valid=%b count=%0d required 0/0", trace_valid, trace_count);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1, 5'(i), 32'(i), 32'h4000 + 32'(4 * i), 5'd0, 5'd0, 0);
            tick();
            n_checks++;
            if (trace_count !== CW'((i > DEPTH) ? DEPTH : i)) begin
                n_fail++;
                $display("FAIL ovf_count_%0d: got %0d required %0d", i, trace_count, (i > DEPTH) ? DEPTH : i);
            end
        end
        drive(0, 0, 0, 0, 5'd5, 5'd0, 0);
        #1;
        n_checks++;
        if (trace_overflow !== 1'b1 || RD1 !== 32'd5) begin
            n_fail++;
            $display("FAIL ovf_flag_reg5: ovf=%b RD1=%h required 1/5", trace_overflow, RD1);
        end
        trace_ready = 1;
        for (int i = 1; i <= DEPTH; i++) begin
            n_checks++;
            if (trace_valid !== 1'b1 || trace_addr !== 5'(i) || trace_data !== 32'(i)) begin
                n_fail++;
                $display("FAIL ovf_drain_%0d: v=%b a=%0d d=%h required 1/%0d/%0d",
                         i, trace_valid, trace_addr, trace_data, i, i);
            end
            tick();
        end
        n_checks++;
        if (trace_valid !== 1'b0 || trace_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_after_drain: valid=%b ovf=%b required 0/1", trace_valid, trace_overflow);
        end
        trace_ready = 0;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 5'(10 + i), 32'hA0 + 32'(i), 32'h5000 + 32'(i), 5'd0, 5'd0, 0);
            tick();
        end
        drive(1, 5'(10 + DEPTH), 32'hA0 + 32'(DEPTH), 32'h5100, 5'd0, 5'd0, 1);
        tick();
        n_checks++;
        if (trace_count !== CW'(DEPTH) || trace_overflow !== 1'b0 || trace_addr !== 5'd11) begin
            n_fail++;
            $display("FAIL full_push_pop: cnt=%0d ovf=%b head=%0d required %0d/0/11",
                     trace_count, trace_overflow, trace_addr, DEPTH);
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= DEPTH; i++) begin
            n_checks++;
            if (trace_addr !== 5'(10 + i) || trace_data !== 32'hA0 + 32'(i)) begin
                n_fail++;
                $display("FAIL full_drain_%0d: a=%0d d=%h required %0d/%h",
                         i, trace_addr, trace_data, 10 + i, 32'hA0 + 32'(i));
            end
            tick();
        end
        trace_ready = 0;
    endtask

    task automatic test_async_reset();
        drive(1, 5'd20, 32'hDEAD0001, 32'h6000, 5'd0, 5'd0, 0);
        tick();
        drive(1, 5'd21, 32'hDEAD0002, 32'h6004, 5'd0, 5'd0, 0);
        tick();
        drive(0, 0, 0, 0, 5'd20, 5'd21, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (trace_valid !== 1'b0 || trace_count !== '0 || RD1 !== 32'd0 || RD2 !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: v=%b cnt=%0d RD1=%h RD2=%h required all 0",
                     trace_valid, trace_count, RD1, RD2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_dual_port();
        drive(1, 5'd8, 32'h0BADF00D, 32'h7000, 5'd0, 5'd0, 1);
        tick();
        drive(1, 5'd7, 32'hA5A5A5A5, 32'h7004, 5'd7, 5'd7, 1);
        #1;
        n_checks++;
        if (RD1 !== 32'hA5A5A5A5 || RD2 !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL dual_bypass: RD1=%h RD2=%h required a5a5a5a5", RD1, RD2);
        end
        A2 = 5'd8;
        #1;
        n_checks++;
        if (RD2 !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL stored_reg8: RD2=%h required 0badf00d", RD2);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [4:0]    a3;
        logic [CW-1:0] ecnt;
        ent_t          h;
        for (int n = 0; n < 400; n++) begin
            a3 = 5'($urandom_range(0, 31));
            drive($urandom_range(0, 3) != 0, a3, $urandom, $urandom,
                  ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom_range(0, 31)),
                  $urandom_range(0, 2) == 0);
            #1;
            n_checks++;
            if (RD1 !== exp_rd(A1) || RD2 !== exp_rd(A2)) begin
                n_fail++;
                $display("FAIL rand_read_%0d: RD1=%h RD2=%h required %h %h", n, RD1, RD2, exp_rd(A1), exp_rd(A2));
            end
            tick();
            ecnt = CW'(q.size());
            if (q.size() > 0) h = q[0];
            else begin h.pc = '0; h.a = '0; h.d = '0; end
            n_checks++;
            if (trace_count !== ecnt || trace_valid !== (q.size() > 0) || trace_overflow !== m_ovf ||
                trace_pc !== h.pc || trace_addr !== h.a || trace_data !== h.d) begin
                n_fail++;
                $display("FAIL rand_trace_%0d: cnt=%0d v=%b ovf=%b pc=%h a=%0d d=%h required %0d/%b/%b/%h/%0d/%h",
                         n, trace_count, trace_valid, trace_overflow, trace_pc, trace_addr, trace_data,
                         ecnt, q.size() > 0, m_ovf, h.pc, h.a, h.d);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_write_bypass();
        test_zero_reg();
        test_overflow();
        test_full_push_pop();
        test_async_reset();
        test_dual_port();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
